id_ex_stage: RTL and testbench

- ID/EX pipeline stage sitting directly downstream of the register file in the pipelined MIPS core.
- Captures register-file read data (rdata1/rdata2), operand indices, immediate and decoded control into the EX-stage register.
- Applies the WB→ID same-cycle bypass, so a value being written back this cycle is captured instead of the stale regfile read.
- Detects load-use hazards, stalls upstream and inserts a bubble. Also supports branch flush and keeps a saturating stall counter.

---
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Captures regfile read data, operand indices, the immediate and decoded control,
// applies the same-cycle WB->ID bypass, detects load-use hazards and inserts
// bubbles on stall or branch flush. Also keeps a saturating count of stall cycles.
//
// Handshake: ex_valid qualifies every ex_* field in the cycle it is high. While
// stall is high, upstream must hold the PC and IF/ID so that the same ID
// instruction is re-presented next cycle. This stage then places a bubble
// (ex_valid=0, ex_ctrl=0) in EX. The stall is combinational from EX state and ID
// inputs only. It never depends on wb_*.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_ctrl,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic [7:0]        ex_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  // Control byte layout: {regwrite, memread, memwrite, memtoreg, alusrc, regdst, aluop[1:0]}
  localparam int CTRL_MEMREAD = 6;
  localparam int CTRL_REGDST  = 2;

  logic              load_use;
  logic              bubble;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [REG_AW-1:0] dest_in;

  // Load-use hazard: the load in EX targets a register that the ID instruction reads.
  // r0 is excluded because a load into r0 never produces a value.
  always_comb begin
    load_use = ex_valid & ex_ctrl[CTRL_MEMREAD] & (ex_rt != '0) & id_valid &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
    stall    = load_use & ~flush;
    bubble   = flush | load_use;
  end

  // WB->ID bypass: a register written back this cycle overrides the stale regfile read.
  always_comb begin
    a_in    = rdata1;
    b_in    = rdata2;
    dest_in = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
    if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs)) a_in = wb_data;
    if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rt)) b_in = wb_data;
  end

  // EX register: reset clears it, a bubble zeroes it, otherwise it loads the ID slot.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_dest  <= '0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_a     <= a_in;
      ex_b     <= b_in;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_dest  <= dest_in;
      ex_ctrl  <= id_valid ? id_ctrl : 8'h00;
    end
  end

  // Stall cycle counter. It saturates at all-ones so that a long run cannot wrap to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. A driver applies one ID-slot stimulus per cycle and
// pushes the expected EX record into exp_q. A monitor pops one record after each
// rising edge and compares it against the DUT outputs.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [DATA_W-1:0] rdata1, rdata2, id_imm, wb_data;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd, wb_rd;
  logic [7:0]        id_ctrl;
  logic              wb_regwrite, flush;
  logic              stall, ex_valid;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest;
  logic [7:0]        ex_ctrl;
  logic [CNT_W-1:0]  stall_count;

  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [7:0]        ctrl;
    logic [CNT_W-1:0]  cnt;
  } rec_t;

  rec_t exp_q[$];
  rec_t model;
  logic model_known = 1'b0;
  logic last_stall  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Control encodings used by the directed tests
  localparam logic [7:0] C_RTYPE = 8'b1000_0110;  // regwrite, regdst, aluop=10
  localparam logic [7:0] C_LW    = 8'b1101_1000;  // regwrite, memread, memtoreg, alusrc

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rdata1(rdata1), .rdata2(rdata2),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver plus reference model. Applies one cycle of ID inputs and predicts the EX contents after the edge.
  task automatic step(input logic r, input logic iv, input logic [DATA_W-1:0] d1,
                      input logic [DATA_W-1:0] d2, input logic [REG_AW-1:0] rs,
                      input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                      input logic [DATA_W-1:0] imm, input logic [7:0] ctrl,
                      input logic wbw, input logic [REG_AW-1:0] wbrd,
                      input logic [DATA_W-1:0] wbd, input logic fl);
    rec_t nxt;
    logic hazard, exp_stall;
    @(negedge clk);
    rst = r; id_valid = iv; rdata1 = d1; rdata2 = d2; id_rs = rs; id_rt = rt;
    id_rd = rd; id_imm = imm; id_ctrl = ctrl; wb_regwrite = wbw; wb_rd = wbrd;
    wb_data = wbd; flush = fl;
    #1;
    // Hazard: the EX instruction is a load whose target (not r0) is read by a valid ID instruction
    hazard = model.v && model.ctrl[6] && (model.rt != 0) && iv && (model.rt == rs || model.rt == rt);
    exp_stall = hazard && !fl;
    if (model_known) check("stall", 64'(stall), 64'(exp_stall));
    nxt = '0;
    if (r) begin
      nxt = '0;
    end else if (hazard || fl) begin
      nxt.cnt = (exp_stall && model.cnt != {CNT_W{1'b1}}) ? model.cnt + 1 : model.cnt;
    end else begin
      nxt.v    = iv;
      nxt.a    = (wbw && wbrd != 0 && wbrd == rs) ? wbd : d1;
      nxt.b    = (wbw && wbrd != 0 && wbrd == rt) ? wbd : d2;
      nxt.imm  = imm;
      nxt.rs   = rs;
      nxt.rt   = rt;
      nxt.dest = ctrl[2] ? rd : rt;
      nxt.ctrl = iv ? ctrl : 8'h00;
      nxt.cnt  = model.cnt;
    end
    exp_q.push_back(nxt);
    model = nxt;
    model_known = 1'b1;
    last_stall = exp_stall;
  endtask

  // Shorthand for an instruction with no writeback activity and no flush
  task automatic issue(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] d1,
                       input logic [DATA_W-1:0] d2, input logic [7:0] ctrl, input logic fl);
    step(1'b0, 1'b1, d1, d2, rs, rt, rd, 32'h0000_0010, ctrl, 1'b0, 5'd0, 32'h0, fl);
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest expected record
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ex_valid", 64'(ex_valid), 64'(e.v));
        check("ex_a", 64'(ex_a), 64'(e.a));
        check("ex_b", 64'(ex_b), 64'(e.b));
        check("ex_imm", 64'(ex_imm), 64'(e.imm));
        check("ex_rs", 64'(ex_rs), 64'(e.rs));
        check("ex_rt", 64'(ex_rt), 64'(e.rt));
        check("ex_dest", 64'(ex_dest), 64'(e.dest));
        check("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
        check("stall_count", 64'(stall_count), 64'(e.cnt));
      end
    end
  end

  // Stimulus
  initial begin
    logic [DATA_W-1:0] r1, r2, imm;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [7:0]        ctrl;
    logic              iv;
    model = '0;
    rst = 1'b1; id_valid = 1'b0; rdata1 = '0; rdata2 = '0; id_rs = '0; id_rt = '0;
    id_rd = '0; id_imm = '0; id_ctrl = '0; wb_regwrite = 1'b0; wb_rd = '0;
    wb_data = '0; flush = 1'b0;

    // Reset for 2 cycles with random inputs
    repeat (2) step(1'b1, 1'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom),
                    5'($urandom), $urandom, 8'($urandom), 1'($urandom), 5'($urandom),
                    $urandom, 1'b0);

    // Plain issue
    step(1'b0, 1'b1, 32'd10, 32'd20, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFC, C_RTYPE,
         1'b0, 5'd0, 32'h0, 1'b0);

    // WB bypass, then r0 is never bypassed
    step(1'b0, 1'b1, 32'd0, 32'd7, 5'd3, 5'd4, 5'd6, 32'h4, C_RTYPE, 1'b1, 5'd3, 32'd123, 1'b0);
    step(1'b0, 1'b1, 32'd55, 32'd8, 5'd0, 5'd4, 5'd6, 32'h4, C_RTYPE, 1'b1, 5'd0, 32'd99, 1'b0);

    // Load-use: the load writes r5, then an add reads r5. One stall, a bubble, then the add re-issues.
    issue(5'd1, 5'd5, 5'd0, 32'd100, 32'd0, C_LW, 1'b0);
    issue(5'd5, 5'd2, 5'd7, 32'd11, 32'd22, C_RTYPE, 1'b0);
    issue(5'd5, 5'd2, 5'd7, 32'd11, 32'd22, C_RTYPE, 1'b0);

    // Flush and hazard in the same cycle: the flush wins and the count does not change
    issue(5'd1, 5'd5, 5'd0, 32'd100, 32'd0, C_LW, 1'b0);
    issue(5'd5, 5'd2, 5'd7, 32'd11, 32'd22, C_RTYPE, 1'b1);
    issue(5'd5, 5'd2, 5'd7, 32'd11, 32'd22, C_RTYPE, 1'b0);

    // Reset arrives during a stall cycle
    issue(5'd1, 5'd6, 5'd0, 32'd1, 32'd0, C_LW, 1'b0);
    step(1'b1, 1'b1, 32'd3, 32'd4, 5'd6, 5'd2, 5'd7, 32'h0, C_RTYPE, 1'b0, 5'd0, 32'h0, 1'b0);
    issue(5'd6, 5'd2, 5'd7, 32'd3, 32'd4, C_RTYPE, 1'b0);

    // Random traffic. Upstream re-presents the ID instruction whenever it was stalled.
    rs = 0; rt = 0; rd = 0; r1 = 0; r2 = 0; imm = 0; ctrl = 0; iv = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        iv   = ($urandom_range(0, 9) != 0);
        rs   = 5'($urandom_range(0, 7));
        rt   = 5'($urandom_range(0, 7));
        rd   = 5'($urandom_range(0, 31));
        r1   = $urandom;
        r2   = $urandom;
        imm  = $urandom;
        ctrl = ($urandom_range(0, 2) == 0) ? (C_LW | 8'($urandom_range(0, 3))) : 8'($urandom);
      end
      step(($urandom_range(0, 49) == 0), iv, r1, r2, rs, rt, rd, imm, ctrl,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) == 0));
    end

    // Saturation: back-to-back dependent loads alternate stall and issue, and the count pins at all-ones
    step(1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 2 * ((1 << CNT_W) + 3) + 1; i++)
      issue(5'd5, 5'd5, 5'd0, 32'(i), 32'd0, C_LW, 1'b0);
    check("stall_count_saturated", 64'(model.cnt), 64'({CNT_W{1'b1}}));

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
